// File: rtl/datapath_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_ctrl_pkg
// Purpose  : Shared encodings for the LEGv8-subset datapath controller:
//            control-word layout, FS/PS codes, opcodes, FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package datapath_ctrl_pkg;

  localparam int CW_W   = 31;
  localparam int K_W    = 64;
  localparam int PS_LSB = 29;
  localparam int PS_W   = 2;
  localparam int DA_LSB = 24;
  localparam int SA_LSB = 19;
  localparam int SB_LSB = 14;
  localparam int FS_LSB = 9;
  localparam int REG_W  = 5;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;

  // FS = {op[2:0], invA, invB}; carry-in follows FS[0]
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [9:0]  OPI_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPI_SUBI = 10'b1101000100;
  localparam logic [5:0]  OPB_B    = 6'b000101;
  localparam logic [6:0]  OPC_CB   = 7'b1011010;
  localparam logic [7:0]  OPC_BC   = 8'b01010100;

  localparam logic [4:0] COND_EQ = 5'h00;
  localparam logic [4:0] COND_NE = 5'h01;
  localparam logic [4:0] COND_GE = 5'h0A;
  localparam logic [4:0] COND_LT = 5'h0B;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EX    = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [CW_W-1:0] CW_NOP = '0;

  typedef struct packed {
    logic [CW_W-1:0] cw_ex;
    logic [CW_W-1:0] cw_mem;
    logic [K_W-1:0]  k;
    logic [1:0]      nxt;
    logic            illegal;
    logic            is_cb;
    logic            cb_nz;
`ifdef FLAGS_EN
    logic            set_flags;
`endif
  } decode_t;

  function automatic logic [CW_W-1:0] pack_cw(
    input logic [1:0] ps,
    input logic [4:0] da,
    input logic [4:0] sa,
    input logic [4:0] sb,
    input logic [4:0] fs,
    input logic       reg_w,
    input logic       ram_w,
    input logic       en_mem,
    input logic       en_alu,
    input logic       en_b,
    input logic       sel_b
  );
    // EN_PC, PCsel and SL are never asserted by this controller
    pack_cw = {ps, da, sa, sb, fs, reg_w, ram_w, en_mem, en_alu, en_b,
               1'b0, sel_b, 1'b0, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : datapath_control_unit_if
// Purpose  : Instruction handshake, datapath status and control outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface datapath_control_unit_if;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  status;
  logic [30:0] controlWord;
  logic [63:0] K;
  logic        halted;
  logic        illegal;

  modport master (
    output instruction, instr_valid, status,
    input  instr_ready, controlWord, K, halted, illegal
  );

  modport slave (
    input  instruction, instr_valid, status,
    output instr_ready, controlWord, K, halted, illegal
  );
endinterface
`default_nettype wire

// File: rtl/datapath_control_unit_decoder.sv
`default_nettype none
// ============================================================================
// Module   : control_decoder
// Purpose  : Combinational IR decode into control words, K and next state.
//            FLAGS_EN adds ADDS/SUBS and B.cond on latched {V,C,N,Z}.
// Revision : 1.0 - initial release
// ============================================================================
module control_decoder
  import datapath_ctrl_pkg::*;
(
  input  logic [31:0] ir,
`ifdef FLAGS_EN
  input  logic [3:0]  flags,
`endif
  output decode_t     dec
);

  logic [4:0]  rd, rn, rm;
  logic [10:0] opc;
  logic        is_r, is_i, r_set;
  logic [4:0]  r_fs, i_fs;

  assign rd  = ir[4:0];
  assign rn  = ir[9:5];
  assign rm  = ir[20:16];
  assign opc = ir[31:21];

  always_comb begin
    is_r  = 1'b1;
    r_fs  = FS_ADD;
    r_set = 1'b0;
    case (opc)
      OP_ADD:  r_fs = FS_ADD;
      OP_SUB:  r_fs = FS_SUB;
      OP_AND:  r_fs = FS_AND;
      OP_ORR:  r_fs = FS_OR;
      OP_EOR:  r_fs = FS_XOR;
`ifdef FLAGS_EN
      OP_ADDS: begin r_fs = FS_ADD; r_set = 1'b1; end
      OP_SUBS: begin r_fs = FS_SUB; r_set = 1'b1; end
`endif
      default: is_r = 1'b0;
    endcase
  end

  always_comb begin
    is_i = 1'b1;
    i_fs = FS_ADD;
    case (ir[31:22])
      OPI_ADDI: i_fs = FS_ADD;
      OPI_SUBI: i_fs = FS_SUB;
      default:  is_i = 1'b0;
    endcase
  end

`ifdef FLAGS_EN
  logic bc_ok, bc_taken;
  always_comb begin
    bc_ok    = 1'b1;
    bc_taken = 1'b0;
    case (ir[4:0])
      COND_EQ: bc_taken = flags[0];
      COND_NE: bc_taken = ~flags[0];
      COND_GE: bc_taken = (flags[1] == flags[3]);
      COND_LT: bc_taken = (flags[1] != flags[3]);
      default: bc_ok    = 1'b0;
    endcase
  end
`endif

  always_comb begin
    dec     = '0;
    dec.nxt = ST_FETCH;
    if (ir == 32'h0) begin
      dec.nxt = ST_HALT;
    end else if (is_r) begin
      dec.cw_ex = pack_cw(PS_INC, rd, rn, rm, r_fs, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef FLAGS_EN
      dec.set_flags = r_set;
`endif
    end else if (is_i) begin
      dec.cw_ex = pack_cw(PS_INC, rd, rn, 5'd0, i_fs, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      dec.k     = {52'd0, ir[21:10]};
    end else if (opc == OP_LDUR) begin
      // address phase only; the register write happens in MEM
      dec.cw_ex  = pack_cw(PS_HOLD, 5'd0, rn, 5'd0, FS_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      dec.cw_mem = pack_cw(PS_INC, rd, rn, 5'd0, FS_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      dec.k      = {{55{ir[20]}}, ir[20:12]};
      dec.nxt    = ST_MEM;
    end else if (opc == OP_STUR) begin
      dec.cw_ex = pack_cw(PS_INC, 5'd0, rn, rd, FS_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      dec.k     = {{55{ir[20]}}, ir[20:12]};
    end else if (ir[31:26] == OPB_B) begin
      dec.cw_ex = pack_cw(PS_BR, 5'd0, 5'd0, 5'd0, FS_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      dec.k     = {{36{ir[25]}}, ir[25:0], 2'b00};
    end else if (ir[31:25] == OPC_CB) begin
      dec.cw_ex = pack_cw(PS_INC, 5'd0, 5'd31, rd, FS_OR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      dec.k     = {{43{ir[23]}}, ir[23:5], 2'b00};
      dec.is_cb = 1'b1;
      dec.cb_nz = ir[24];
`ifdef FLAGS_EN
    end else if (ir[31:24] == OPC_BC && bc_ok) begin
      dec.cw_ex = pack_cw(bc_taken ? PS_BR : PS_INC, 5'd0, 5'd0, 5'd0, FS_AND,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      dec.k     = {{43{ir[23]}}, ir[23:5], 2'b00};
`endif
    end else begin
      dec.cw_ex   = pack_cw(PS_INC, 5'd0, 5'd0, 5'd0, FS_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      dec.illegal = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/datapath_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : datapath_control_unit
// Purpose  : FETCH/EX/MEM/HALT sequencer driving controlWord and K.
//            FLAGS_EN enables the NZCV flag register (ADDS/SUBS/B.cond).
// Revision : 1.0 - initial release
// ============================================================================
module datapath_control_unit
  import datapath_ctrl_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  datapath_control_unit_if.slave  bus
);

  logic [1:0]      state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  decode_t         dec;
  logic [CW_W-1:0] cw;
  logic [K_W-1:0]  k;

`ifdef FLAGS_EN
  logic [3:0] flags_q, flags_d;

  control_decoder u_decoder (
    .ir    (ir_q),
    .flags (flags_q),
    .dec   (dec)
  );
`else
  control_decoder u_decoder (
    .ir  (ir_q),
    .dec (dec)
  );
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: if (bus.instr_valid) begin
        ir_d    = bus.instruction;
        state_d = ST_EX;
      end
      ST_EX:   state_d = dec.nxt;
      ST_MEM:  state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

`ifdef FLAGS_EN
  always_comb begin
    flags_d = flags_q;
    if (state_q == ST_EX && dec.set_flags)
      flags_d = bus.status[4:1];
  end
`endif

  always_comb begin
    cw = CW_NOP;
    k  = '0;
    if (state_q == ST_EX) begin
      cw = dec.cw_ex;
      k  = dec.k;
      // the only combinational path from status to the outputs
      if (dec.is_cb)
        cw[PS_LSB +: PS_W] = (bus.status[0] ^ dec.cb_nz) ? PS_BR : PS_INC;
    end else if (state_q == ST_MEM) begin
      cw = dec.cw_mem;
      k  = dec.k;
    end
  end

  assign bus.controlWord = cw;
  assign bus.K           = k;
  assign bus.instr_ready = (state_q == ST_FETCH) && !reset;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.illegal     = (state_q == ST_EX) && dec.illegal;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
`ifdef FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
`ifdef FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datapath_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_control_unit
// Purpose  : Scoreboard bench for datapath_control_unit (honours FLAGS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_control_unit;

  typedef struct {
    logic [30:0] cw;
    logic [63:0] k;
    logic        ill;
    logic        has_mem;
    logic [30:0] mem_cw;
    logic        halt;
    logic        flip;
    logic [1:0]  alt_ps;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  datapath_control_unit_if bus ();

  datapath_control_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] cwf(input logic [1:0] ps, input logic [4:0] da, sa, sb_r, fs,
                                      input logic regw, ramw, enmem, enalu, enb, selb);
    cwf = {ps, da, sa, sb_r, fs, regw, ramw, enmem, enalu, enb, 1'b0, selb, 2'b00};
  endfunction

  function automatic exp_t mk(input logic [30:0] cw, input logic [63:0] k);
    exp_t e;
    e.cw = cw; e.k = k; e.ill = 1'b0; e.has_mem = 1'b0; e.mem_cw = '0;
    e.halt = 1'b0; e.flip = 1'b0; e.alt_ps = 2'b00;
    return e;
  endfunction

  // called at a negedge in FETCH; returns at the negedge after the instruction retires
  task automatic send(input logic [31:0] ins, input exp_t e);
    exp_t x;
    int   n;
    sb.push_back(e);
    bus.instruction = ins;
    bus.instr_valid = 1'b1;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("accept_wait", 64'(n < 20), 64'd1);
    @(negedge clock);
    bus.instr_valid = 1'b0;
    x = sb.pop_front();
    chk("ex_cw", 64'(bus.controlWord), 64'(x.cw));
    chk("ex_k", bus.K, x.k);
    chk("ex_illegal", 64'(bus.illegal), 64'(x.ill));
    chk("ex_ready", 64'(bus.instr_ready), 64'd0);
    if (x.flip) begin
      bus.status[0] = ~bus.status[0];
      #1;
      chk("cb_ps_flip", 64'(bus.controlWord[30:29]), 64'(x.alt_ps));
      bus.status[0] = ~bus.status[0];
      #1;
    end
    if (x.has_mem) begin
      @(negedge clock);
      chk("mem_cw", 64'(bus.controlWord), 64'(x.mem_cw));
      chk("mem_k", bus.K, x.k);
      chk("mem_ready", 64'(bus.instr_ready), 64'd0);
    end
    @(negedge clock);
    if (x.halt) begin
      chk("halt_halted", 64'(bus.halted), 64'd1);
      chk("halt_ready", 64'(bus.instr_ready), 64'd0);
    end else begin
      chk("fetch_ready", 64'(bus.instr_ready), 64'd1);
      chk("fetch_cw", 64'(bus.controlWord), 64'd0);
      chk("fetch_illegal", 64'(bus.illegal), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    bus.instruction = '0;
    bus.instr_valid = 1'b0;
    bus.status      = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cw", 64'(bus.controlWord), 64'd0);
    chk("rst_k", bus.K, 64'd0);
    chk("rst_ready", 64'(bus.instr_ready), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.instr_ready), 64'd1);

    // ADDI X5,XZR,#24
    send(32'h910063E5, mk(cwf(2'b01, 5'd5, 5'd31, 5'd0, 5'b01000, 1, 0, 0, 1, 0, 1), 64'd24));
    // ADD X1,X5,X7
    send(32'h8B0700A1, mk(cwf(2'b01, 5'd1, 5'd5, 5'd7, 5'b01000, 1, 0, 0, 1, 0, 0), 64'd0));
    // SUBI X2,X2,#1
    send(32'hD1000442, mk(cwf(2'b01, 5'd2, 5'd2, 5'd0, 5'b01001, 1, 0, 0, 1, 0, 1), 64'd1));
    // ORR X3,X1,X2
    send(32'hAA020023, mk(cwf(2'b01, 5'd3, 5'd1, 5'd2, 5'b00100, 1, 0, 0, 1, 0, 0), 64'd0));
    // LDUR X0,[X7,#-8]
    e = mk(cwf(2'b00, 5'd0, 5'd7, 5'd0, 5'b01000, 0, 0, 0, 0, 0, 1), 64'hFFFF_FFFF_FFFF_FFF8);
    e.has_mem = 1'b1;
    e.mem_cw  = cwf(2'b01, 5'd0, 5'd7, 5'd0, 5'b01000, 1, 0, 1, 0, 0, 1);
    send(32'hF85F80E0, e);
    // STUR X2,[X4,#16]
    send(32'hF8010082, mk(cwf(2'b01, 5'd0, 5'd4, 5'd2, 5'b01000, 0, 1, 0, 0, 1, 1), 64'd16));
    // B #-1
    send(32'h17FFFFFF, mk(31'h4000_0000, 64'hFFFF_FFFF_FFFF_FFFC));
    // CBZ X3,#+4 taken with Zf=1, then Zf=0 in the same EX
    bus.status = 5'b00001;
    e = mk(cwf(2'b10, 5'd0, 5'd31, 5'd3, 5'b00100, 0, 0, 0, 0, 0, 0), 64'd16);
    e.flip = 1'b1; e.alt_ps = 2'b01;
    send(32'hB4000083, e);
    bus.status = 5'b00000;
    send(32'hB4000083, mk(cwf(2'b01, 5'd0, 5'd31, 5'd3, 5'b00100, 0, 0, 0, 0, 0, 0), 64'd16));
    // CBNZ X3,#+4 with Zf=0
    send(32'hB5000083, mk(cwf(2'b10, 5'd0, 5'd31, 5'd3, 5'b00100, 0, 0, 0, 0, 0, 0), 64'd16));
    // opcode 0x7FF
    e = mk(31'h2000_0000, 64'd0);
    e.ill = 1'b1;
    send(32'hFFE00000, e);

`ifdef FLAGS_EN
    bus.status = 5'b00010;
    send(32'hAB0700A1, mk(cwf(2'b01, 5'd1, 5'd5, 5'd7, 5'b01000, 1, 0, 0, 1, 0, 0), 64'd0));
    bus.status = 5'b00000;
    send(32'h54000040, mk(31'h4000_0000, 64'd8));
    send(32'h54000041, mk(31'h2000_0000, 64'd8));
`else
    e = mk(31'h2000_0000, 64'd0);
    e.ill = 1'b1;
    send(32'hAB0700A1, e);
    send(32'h54000040, e);
`endif

    // reset during MEM of LDUR
    bus.instruction = 32'hF85F80E0;
    bus.instr_valid = 1'b1;
    @(negedge clock);
    bus.instr_valid = 1'b0;
    @(negedge clock);
    chk("abort_in_mem", 64'(bus.controlWord[6]), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_cw", 64'(bus.controlWord), 64'd0);
    chk("abort_k", bus.K, 64'd0);
    chk("abort_ready", 64'(bus.instr_ready), 64'd1);
    @(negedge clock);

    // HALT then valid held high
    e = mk(31'h0, 64'd0);
    e.halt = 1'b1;
    send(32'h00000000, e);
    bus.instruction = 32'h8B0700A1;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("halt_sticky", 64'(bus.halted), 64'd1);
      chk("halt_noready", 64'(bus.instr_ready), 64'd0);
      chk("halt_cw", 64'(bus.controlWord), 64'd0);
    end
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("unhalt_halted", 64'(bus.halted), 64'd0);
    chk("unhalt_ready", 64'(bus.instr_ready), 64'd1);
    @(negedge clock);
    send(32'h8B0700A1, mk(cwf(2'b01, 5'd1, 5'd5, 5'd7, 5'b01000, 1, 0, 0, 1, 0, 0), 64'd0));

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
